// File: rtl/aoi21_resp_checker.sv
// Exhaustive AOI21 self-test: steps {a,b1,b2} through 0..7, samples zn after a settle
// window and reports signature, mismatch count, first failing vector and pass/fail.
module aoi21_resp_checker #(
    parameter int unsigned SETTLE_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       zn,
    output logic       a,
    output logic       b1,
    output logic       b2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] sig,
    output logic [2:0] first_fail,
    output logic       first_fail_valid
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned VEC_W = 3;
    localparam int unsigned ERR_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [VEC_W-1:0]   v_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [VEC_W-1:0]   drv_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [ERR_W-1:0]   err_q;
    logic [7:0]         sig_q;
    logic [VEC_W-1:0]   ff_q;
    logic               ffv_q;

    logic               exp_c;
    logic               miss_c;
    logic [ERR_W-1:0]   err_d;

    // Ideal AOI21 response for the vector currently applied
    always_comb begin
        exp_c  = ~(v_q[2] | (v_q[1] & v_q[0]));
        miss_c = zn ^ exp_c;
        err_d  = err_q + ERR_W'(miss_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            drv_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            sig_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SETTLE;
                        v_q     <= '0;
                        cnt_q   <= '0;
                        drv_q   <= '0;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        sig_q   <= '0;
                        ff_q    <= '0;
                        ffv_q   <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    sig_q[v_q] <= zn;
                    err_q      <= err_d;
                    if (miss_c && !ffv_q) begin
                        ff_q  <= v_q;
                        ffv_q <= 1'b1;
                    end
                    if (v_q == VEC_W'(7)) begin
                        // Verdict includes the final vector's outcome so it is valid alongside done
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        drv_q   <= '0;
                        pass_q  <= (err_d == '0);
                    end else begin
                        state_q <= SETTLE;
                        v_q     <= v_q + VEC_W'(1);
                        drv_q   <= v_q + VEC_W'(1);
                        cnt_q   <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {a, b1, b2}      = drv_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign sig              = sig_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: doc/aoi21_resp_checker.md
# aoi21_resp_checker

Self-test engine for the AOI21 standard cell (ZN = !(A | (B1 & B2))). It drives all eight input vectors into a cell under test and waits a programmable settle time on each. It samples ZN, compares it against the ideal AOI21 response, and reports a per-vector response signature, a mismatch count and a pass/fail verdict. It sits beside the cell library as the checking end of exhaustive truth-table runs, so cell checks can be run and judged in hardware or simulation without any display output.

## Interface
- SETTLE_CYCLES, default 10: cycles each vector is held before sampling; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a run; accepted only in IDLE.
- zn  input  1  ZN output of the cell under test.
- a  output  1  A input to the cell under test.
- b1  output  1  B1 input to the cell under test.
- b2  output  1  B2 input to the cell under test.
- busy  output  1  high from the cycle after start is accepted through the last SAMPLE cycle.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  high when err_count == 0 at the end of a run; held until the next accepted start.
- err_count  output  4  number of mismatching vectors in the last run, 0..8.
- sig  output  8  sig[i] = sampled ZN for vector i.
- first_fail  output  3  index of the first mismatching vector; valid only when first_fail_valid = 1.
- first_fail_valid  output  1  high if any mismatch occurred in the last run.

## Operation
- Vector index v (3 bits) maps to {a,b1,b2} = v, with a as MSB. Vectors run in order 0..7.
- Expected response exp(v) = !(v[2] | (v[1] & v[0])). The expected signature is 8'h07.
- FSM states:
  - IDLE: a, b1 and b2 are driven 0.
  - SETTLE.
  - SAMPLE.
  - DONE.
- IDLE -> SETTLE on start = 1. On acceptance:
  - v = 0 and the settle counter = 0.
  - err_count, sig, first_fail and first_fail_valid are cleared.
  - pass = 0.
- SETTLE: {a,b1,b2} = v. The counter increments each cycle. On the cycle with counter == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: {a,b1,b2} = v (still stable). At the edge leaving SAMPLE:
  - sig[v] <= zn.
  - If zn != exp(v): err_count increments. If first_fail_valid is still 0, first_fail <= v and first_fail_valid <= 1.
  - If v == 7, go to DONE. Otherwise v <= v+1, counter <= 0, and go to SETTLE.
- DONE (exactly one cycle):
  - done = 1, busy = 0.
  - pass = (err_count == 0) is registered and held.
  - {a,b1,b2} = 0.
  - Next state is IDLE.
- start outside IDLE (SETTLE, SAMPLE, DONE) is ignored and is not queued.
- err_count cannot overflow: it is 4 bits wide and holds at most 8.
- Results (sig, err_count, first_fail*, pass) hold their values in IDLE indefinitely.

## Timing
- Reset (asynchronous, immediate): state IDLE, v = 0, counter = 0, a = b1 = b2 = 0, busy = 0, done = 0, pass = 0, err_count = 0, sig = 0, first_fail = 0, first_fail_valid = 0.
- Reset asserted mid-run aborts the run with all of the above values. A new start after reset deasserts runs normally from vector 0.
- start sampled high at edge E0 -> busy = 1 and vector 0 driven from E0 onward.
- Each vector is held SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE, then 1 in SAMPLE.
- zn is sampled at edge E0 + (v+1)(SETTLE_CYCLES+1).
- The last sample is at E0 + 8(SETTLE_CYCLES+1). done is high in the following cycle. With the default, that is the cycle after E88.
- All outputs are registered; there are no combinational paths from zn or start to any output.

## Test plan
- Ideal AOI21 model on zn, SETTLE_CYCLES = 10, start pulse -> done one cycle after E88, sig = 8'h07, err_count = 0, pass = 1, first_fail_valid = 0; {a,b1,b2} steps 000..111, each held 11 cycles.
- zn tied 0 -> sig = 8'h00, err_count = 3, pass = 0, first_fail = 0, first_fail_valid = 1.
- zn tied 1 -> sig = 8'hFF, err_count = 5, pass = 0, first_fail = 3.
- zn = A | (B1 & B2) (inverted cell) -> sig = 8'hF8, err_count = 8, first_fail = 0; zn with 2-cycle model delay and SETTLE_CYCLES = 1 -> nonzero err_count; same model with SETTLE_CYCLES = 4 -> pass = 1.
- rst pulsed while v = 4 in SETTLE -> all outputs return to reset values immediately; a following start with the ideal model -> pass = 1, sig = 8'h07.
- start re-pulsed during SETTLE and during DONE -> ignored, run timing unchanged; second start after a failing run -> err_count and sig are cleared at acceptance, and the final results reflect only the second run.
